// File: rtl/tsu_q_rgs.sv
// rtl/tsu_q_rgs.sv - TSU queue register interface with per-channel pop FSM; optional irq via TSU_Q_IRQ_EN
module tsu_q_rgs #(
    parameter int NUM_CH     = 2,
    parameter int Q_WORDS    = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_in,
    input  logic                         rd_in,
    input  logic [7:0]                   addr_in,
    input  logic [31:0]                  data_in,
    output logic [31:0]                  data_out,
    output logic [NUM_CH-1:0]            q_rst_out,
    output logic [NUM_CH-1:0]            q_rd_en_out,
    input  logic [NUM_CH-1:0]            q_rd_vld_in,
    input  logic [NUM_CH*Q_WORDS*32-1:0] q_data_in,
    input  logic [NUM_CH*8-1:0]          q_stat_in,
    output logic [NUM_CH*8-1:0]          q_ptp_msgid_mask_out,
    output logic                         irq_out
);

    localparam int         SW        = Q_WORDS * 32;
    localparam logic [7:0] TMO_INIT  = 8'(RD_TIMEOUT);
    localparam logic [2:0] OFF_LAST  = 3'(4 + Q_WORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t      state_q   [NUM_CH];
    state_t      state_d   [NUM_CH];
    logic [7:0]  timer_q   [NUM_CH];
    logic [7:0]  timer_d   [NUM_CH];
    logic [15:0] pop_cnt_q [NUM_CH];
    logic [15:0] pop_cnt_d [NUM_CH];
    logic [7:0]  mask_q    [NUM_CH];
    logic [7:0]  mask_d    [NUM_CH];
    logic [31:0] shadow_q  [NUM_CH][Q_WORDS];
    logic [31:0] shadow_d  [NUM_CH][Q_WORDS];

    logic [NUM_CH-1:0] ok_q, ok_d, tmo_q, tmo_d, empty_q, empty_d;
    logic [NUM_CH-1:0] auto_pop_q, auto_pop_d, irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] rd_en_q, rd_en_d, q_rst_q, q_rst_d;
    logic [31:0]       data_q, data_d, rdata;
    logic              irq_q, irq_d;

    logic [2:0] a_ch, a_off;
    logic       unused_bits;

    assign a_ch        = addr_in[7:5];
    assign a_off       = addr_in[4:2];
    assign unused_bits = ^{addr_in[1:0], data_in[23:12], data_in[9:3]};

    // Read mux: decodes channel/offset against current register state (pre-write on same-cycle access)
    always_comb begin
        rdata = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (a_ch == 3'(c)) begin
                case (a_off)
                    3'd0: rdata = {28'd0, irq_en_q[c], auto_pop_q[c], 2'b00};
                    3'd1: rdata = {pop_cnt_q[c], 4'd0, empty_q[c], tmo_q[c], ok_q[c],
                                   (state_q[c] != ST_IDLE), q_stat_in[c*8 +: 8]};
                    3'd2: rdata = {mask_q[c], 24'd0};
                    default: begin
                        for (int k = 0; k < Q_WORDS; k++) begin
                            if (a_off == 3'(4 + k)) rdata = shadow_q[c][k];
                        end
                    end
                endcase
            end
        end
        data_d = rd_in ? rdata : data_q;
    end

    // Per-channel command decode, status bookkeeping and pop handshake FSM next state
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            logic hit, wr_ctrl, rd_req, q_rst_cmd;
            state_d[c]    = state_q[c];
            timer_d[c]    = timer_q[c];
            pop_cnt_d[c]  = pop_cnt_q[c];
            mask_d[c]     = mask_q[c];
            ok_d[c]       = ok_q[c];
            tmo_d[c]      = tmo_q[c];
            empty_d[c]    = empty_q[c];
            auto_pop_d[c] = auto_pop_q[c];
            irq_en_d[c]   = irq_en_q[c];
            rd_en_d[c]    = 1'b0;
            q_rst_d[c]    = 1'b0;
            for (int k = 0; k < Q_WORDS; k++) shadow_d[c][k] = shadow_q[c][k];

            hit       = (a_ch == 3'(c));
            wr_ctrl   = wr_in & hit & (a_off == 3'd0);
            q_rst_cmd = wr_ctrl & data_in[1];
            rd_req    = (wr_ctrl & data_in[0]) |
                        (rd_in & hit & auto_pop_q[c] & (a_off == OFF_LAST));

            if (wr_ctrl) begin
                auto_pop_d[c] = data_in[2];
`ifdef TSU_Q_IRQ_EN
                irq_en_d[c]   = data_in[3];
`else
                irq_en_d[c]   = 1'b0;
`endif
            end
            if (wr_in & hit & (a_off == 3'd2)) mask_d[c] = data_in[31:24];
            if (wr_in & hit & (a_off == 3'd1)) begin
                if (data_in[10]) tmo_d[c]   = 1'b0;
                if (data_in[11]) empty_d[c] = 1'b0;
            end

            case (state_q[c])
                ST_IDLE: begin
                    if (rd_req) begin
                        if (q_stat_in[c*8 +: 8] == 8'd0) empty_d[c] = 1'b1;
                        else                             state_d[c] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    rd_en_d[c] = 1'b1;
                    ok_d[c]    = 1'b0;
                    timer_d[c] = TMO_INIT;
                    state_d[c] = ST_WAIT;
                end
                ST_WAIT: begin
                    if (q_rd_vld_in[c]) begin
                        for (int k = 0; k < Q_WORDS; k++)
                            shadow_d[c][k] = q_data_in[c*SW + (Q_WORDS-1-k)*32 +: 32];
                        ok_d[c]      = 1'b1;
                        pop_cnt_d[c] = pop_cnt_q[c] + 16'd1;
                        state_d[c]   = ST_IDLE;
                    end else if (timer_q[c] == 8'd1) begin
                        tmo_d[c]   = 1'b1;
                        state_d[c] = ST_IDLE;
                    end else begin
                        timer_d[c] = timer_q[c] - 8'd1;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase

            // Queue reset overrides everything in flight, including a coincident valid
            if (q_rst_cmd) begin
                q_rst_d[c] = 1'b1;
                rd_en_d[c] = 1'b0;
                state_d[c] = ST_IDLE;
                ok_d[c]    = 1'b0;
                empty_d[c] = 1'b0;
                pop_cnt_d[c] = 16'd0;
                for (int k = 0; k < Q_WORDS; k++) shadow_d[c][k] = shadow_q[c][k];
            end
        end
    end

    // Interrupt level: registered OR of enabled channel conditions
    always_comb begin
        irq_d = 1'b0;
`ifdef TSU_Q_IRQ_EN
        for (int c = 0; c < NUM_CH; c++)
            irq_d = irq_d | (irq_en_q[c] & (ok_q[c] | tmo_q[c] | (q_stat_in[c*8 +: 8] != 8'd0)));
`endif
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= ST_IDLE;
                timer_q[c]   <= 8'd0;
                pop_cnt_q[c] <= 16'd0;
                mask_q[c]    <= 8'd0;
                for (int k = 0; k < Q_WORDS; k++) shadow_q[c][k] <= 32'd0;
            end
            ok_q       <= '0;
            tmo_q      <= '0;
            empty_q    <= '0;
            auto_pop_q <= '0;
            irq_en_q   <= '0;
            rd_en_q    <= '0;
            q_rst_q    <= '0;
            data_q     <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                timer_q[c]   <= timer_d[c];
                pop_cnt_q[c] <= pop_cnt_d[c];
                mask_q[c]    <= mask_d[c];
                for (int k = 0; k < Q_WORDS; k++) shadow_q[c][k] <= shadow_d[c][k];
            end
            ok_q       <= ok_d;
            tmo_q      <= tmo_d;
            empty_q    <= empty_d;
            auto_pop_q <= auto_pop_d;
            irq_en_q   <= irq_en_d;
            rd_en_q    <= rd_en_d;
            q_rst_q    <= q_rst_d;
            data_q     <= data_d;
            irq_q      <= irq_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_mask
            assign q_ptp_msgid_mask_out[g*8 +: 8] = mask_q[g];
        end
    endgenerate

    assign data_out    = data_q;
    assign q_rd_en_out = rd_en_q;
    assign q_rst_out   = q_rst_q;
    assign irq_out     = irq_q;

endmodule

// File: tb/tb_tsu_q_rgs.sv
// tb/tb_tsu_q_rgs.sv - directed self-checking bench for tsu_q_rgs
module tb_tsu_q_rgs;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr, rd;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  data_out;
    logic [1:0]   q_rst_out, q_rd_en_out, vld;
    logic [255:0] qdata;
    logic [15:0]  qstat;
    logic [15:0]  mask_out;
    logic         irq_out;

    int n_cmp = 0;
    int n_fail = 0;
    int pops [2] = '{0, 0};
    int rsts [2] = '{0, 0};

    tsu_q_rgs #(.NUM_CH(2), .Q_WORDS(4), .RD_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .wr_in(wr), .rd_in(rd), .addr_in(addr),
        .data_in(wdata), .data_out(data_out), .q_rst_out(q_rst_out),
        .q_rd_en_out(q_rd_en_out), .q_rd_vld_in(vld), .q_data_in(qdata),
        .q_stat_in(qstat), .q_ptp_msgid_mask_out(mask_out), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (q_rd_en_out[c]) pops[c]++;
            if (q_rst_out[c])   rsts[c]++;
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d = data_out;
    endtask

    task automatic pulse_vld(input int c);
        vld[c] = 1'b1;
        @(negedge clk);
        vld = 2'b00;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", data_out); end
        n_cmp++; if (q_rd_en_out !== 2'b00) begin n_fail++; $display("FAIL rst_rd_en got %b want 00", q_rd_en_out); end
        n_cmp++; if (q_rst_out !== 2'b00) begin n_fail++; $display("FAIL rst_q_rst got %b want 00", q_rst_out); end
        n_cmp++; if (mask_out !== 16'd0) begin n_fail++; $display("FAIL rst_mask got %h want 0", mask_out); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq_out); end
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_stat got %h want 0", r); end
    endtask

    task automatic test_pop;
        logic [31:0] r;
        qstat[15:8] = 8'd3;
        qdata[255:128] = {32'hA, 32'hB, 32'hC, 32'hD};
        do_write(8'h20, 32'h1);
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h00000103) begin n_fail++; $display("FAIL pop_busy got %h want 00000103", r); end
        repeat (2) @(negedge clk);
        pulse_vld(1);
        qdata[255:128] = '0;
        n_cmp++; if (pops[1] !== 1 || pops[0] !== 0) begin n_fail++; $display("FAIL pop_pulses got %0d/%0d want 1/0", pops[1], pops[0]); end
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h00010203) begin n_fail++; $display("FAIL pop_stat got %h want 00010203", r); end
        for (int k = 0; k < 4; k++) begin
            do_read(8'h30 + 8'(4*k), r);
            n_cmp++; if (r !== 32'(10 + k)) begin n_fail++; $display("FAIL pop_data%0d got %h want %h", k, r, 32'(10 + k)); end
        end
    endtask

    task automatic test_earliest_vld;
        logic [31:0] r;
        do_write(8'h20, 32'h1);
        @(negedge clk);
        n_cmp++; if (q_rd_en_out !== 2'b10) begin n_fail++; $display("FAIL early_rd_en got %b want 10", q_rd_en_out); end
        qdata[255:128] = {32'hE0, 32'hE1, 32'hE2, 32'hE3};
        pulse_vld(1);
        n_cmp++; if (q_rd_en_out !== 2'b00) begin n_fail++; $display("FAIL early_rd_en_off got %b want 00", q_rd_en_out); end
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h00020203) begin n_fail++; $display("FAIL early_stat got %h want 00020203", r); end
        do_read(8'h30, r);
        n_cmp++; if (r !== 32'hE0) begin n_fail++; $display("FAIL early_data got %h want e0", r); end
    endtask

    task automatic test_q_rst;
        logic [31:0] r;
        int rbase;
        rbase = rsts[1];
        do_write(8'h20, 32'h1);
        @(negedge clk);
        qdata[255:128] = {32'hF0, 32'hF1, 32'hF2, 32'hF3};
        vld = 2'b10;
        do_write(8'h20, 32'h2);
        vld = 2'b00;
        n_cmp++; if (q_rst_out !== 2'b10) begin n_fail++; $display("FAIL qrst_pulse got %b want 10", q_rst_out); end
        @(negedge clk);
        n_cmp++; if (q_rst_out !== 2'b00) begin n_fail++; $display("FAIL qrst_pulse_end got %b want 00", q_rst_out); end
        n_cmp++; if (rsts[1] !== rbase + 1) begin n_fail++; $display("FAIL qrst_count got %0d want %0d", rsts[1], rbase + 1); end
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h00000003) begin n_fail++; $display("FAIL qrst_stat got %h want 00000003", r); end
        do_read(8'h30, r);
        n_cmp++; if (r !== 32'hE0) begin n_fail++; $display("FAIL qrst_shadow got %h want e0", r); end
    endtask

    task automatic test_empty;
        logic [31:0] r;
        int pbase;
        pbase = pops[0];
        qstat[7:0] = 8'd0;
        do_write(8'h00, 32'h1);
        repeat (3) @(negedge clk);
        n_cmp++; if (pops[0] !== pbase) begin n_fail++; $display("FAIL empty_nopop got %0d want %0d", pops[0], pbase); end
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000800) begin n_fail++; $display("FAIL empty_flag got %h want 00000800", r); end
        do_write(8'h04, 32'h00000800);
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL empty_w1c got %h want 0", r); end
    endtask

    task automatic test_timeout;
        logic [31:0] r;
        int pbase;
        pbase = pops[0];
        qstat[7:0] = 8'd2;
        do_write(8'h00, 32'h1);
        repeat (14) @(negedge clk);
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000102) begin n_fail++; $display("FAIL tmo_busy15 got %h want 00000102", r); end
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000102) begin n_fail++; $display("FAIL tmo_busy16 got %h want 00000102", r); end
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000402) begin n_fail++; $display("FAIL tmo_set got %h want 00000402", r); end
        qdata[127:0] = {32'h77, 32'h78, 32'h79, 32'h7A};
        pulse_vld(0);
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000402) begin n_fail++; $display("FAIL tmo_late_vld got %h want 00000402", r); end
        do_read(8'h10, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL tmo_shadow got %h want 0", r); end
        n_cmp++; if (pops[0] !== pbase + 1) begin n_fail++; $display("FAIL tmo_pops got %0d want %0d", pops[0], pbase + 1); end
        do_write(8'h04, 32'h00000400);
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000002) begin n_fail++; $display("FAIL tmo_w1c got %h want 00000002", r); end
    endtask

    task automatic test_auto_pop;
        logic [31:0] r;
        logic [31:0] prev;
        int pbase;
        pbase = pops[0];
        prev = 32'h0;
        qstat[7:0] = 8'd5;
        do_write(8'h00, 32'h4);
        for (int i = 0; i < 3; i++) begin
            do_read(8'h1C, r);
            n_cmp++; if (r !== prev) begin n_fail++; $display("FAIL ap_read%0d got %h want %h", i, r, prev); end
            do_write(8'h00, 32'h5);
            qdata[127:0] = {32'(i*16+1), 32'(i*16+2), 32'(i*16+3), 32'(i*16+4)};
            pulse_vld(0);
            prev = 32'(i*16+4);
        end
        n_cmp++; if (pops[0] !== pbase + 3) begin n_fail++; $display("FAIL ap_pops got %0d want %0d", pops[0], pbase + 3); end
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00030205) begin n_fail++; $display("FAIL ap_stat got %h want 00030205", r); end
        do_write(8'h00, 32'h0);
        do_read(8'h1C, r);
        n_cmp++; if (r !== 32'h24) begin n_fail++; $display("FAIL ap_last got %h want 24", r); end
        repeat (3) @(negedge clk);
        n_cmp++; if (pops[0] !== pbase + 3) begin n_fail++; $display("FAIL ap_off_pops got %0d want %0d", pops[0], pbase + 3); end
        do_read(8'h10, r);
        n_cmp++; if (r !== 32'h21) begin n_fail++; $display("FAIL ap_word0 got %h want 21", r); end
    endtask

    task automatic test_mask;
        logic [31:0] r;
        do_write(8'h08, 32'hAB00_0000);
        do_write(8'h28, 32'h5C12_3456);
        do_write(8'h48, 32'hFFFF_FFFF);
        n_cmp++; if (mask_out !== 16'h5CAB) begin n_fail++; $display("FAIL mask_out got %h want 5cab", mask_out); end
        do_read(8'h28, r);
        n_cmp++; if (r !== 32'h5C00_0000) begin n_fail++; $display("FAIL mask_read got %h want 5c000000", r); end
        do_read(8'h48, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL bad_ch got %h want 0", r); end
        do_read(8'h0C, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reserved got %h want 0", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        wr = 1'b1; rd = 1'b1; addr = 8'h08; wdata = 32'h1100_0000;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (data_out !== 32'hAB00_0000) begin n_fail++; $display("FAIL rw_pre got %h want ab000000", data_out); end
        do_read(8'h08, r);
        n_cmp++; if (r !== 32'h1100_0000) begin n_fail++; $display("FAIL rw_post got %h want 11000000", r); end
        n_cmp++; if (mask_out !== 16'h5C11) begin n_fail++; $display("FAIL rw_mask got %h want 5c11", mask_out); end
    endtask

    task automatic test_irq;
        logic [31:0] r;
        do_write(8'h00, 32'h8);
        do_read(8'h00, r);
`ifdef TSU_Q_IRQ_EN
        n_cmp++; if (r !== 32'h8) begin n_fail++; $display("FAIL irq_ctrl got %h want 8", r); end
        n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL irq_ch0 got %b want 1", irq_out); end
        do_write(8'h00, 32'h0);
        qstat[15:8] = 8'd1;
        do_write(8'h20, 32'h9);
        qstat[15:8] = 8'd0;
        @(negedge clk);
        pulse_vld(1);
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_pre got %b want 0", irq_out); end
        @(negedge clk);
        n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b want 1", irq_out); end
`else
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL irq_ctrl got %h want 0", r); end
        repeat (2) @(negedge clk);
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_tied got %b want 0", irq_out); end
        qstat[15:8] = 8'd1;
        do_write(8'h20, 32'h1);
        qstat[15:8] = 8'd0;
        @(negedge clk);
        pulse_vld(1);
`endif
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] r;
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h00010200) begin n_fail++; $display("FAIL pre_rst_stat got %h want 00010200", r); end
        qstat[7:0] = 8'd1;
        do_write(8'h00, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", data_out); end
        n_cmp++; if (q_rd_en_out !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rd_en got %b want 00", q_rd_en_out); end
        n_cmp++; if (mask_out !== 16'd0) begin n_fail++; $display("FAIL mid_rst_mask got %h want 0", mask_out); end
        n_cmp++; if (irq_out !== 1'b0 || q_rst_out !== 2'b00) begin n_fail++; $display("FAIL mid_rst_misc got %b/%b want 0/00", irq_out, q_rst_out); end
        @(negedge clk);
        rst = 1'b1;
        do_read(8'h04, r);
        n_cmp++; if (r !== 32'h00000001) begin n_fail++; $display("FAIL mid_rst_stat got %h want 00000001", r); end
        do_read(8'h24, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mid_rst_stat1 got %h want 0", r); end
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = 8'h0; wdata = 32'h0;
        vld = 2'b00; qdata = '0; qstat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset;
        test_pop;
        test_earliest_vld;
        test_q_rst;
        test_empty;
        test_timeout;
        test_auto_pop;
        test_mask;
        test_back_to_back;
        test_irq;
        test_reset_mid_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tsu_q_rgs.md
# tsu_q_rgs

Parametrised register interface for the RX/TX timestamp-unit queues: NUM_CH identical channels, each with control, status, PTP message-ID mask and a Q_WORDS-word data window on the generic 8-bit-address bus. It replaces the fixed delay-chain queue read with a per-channel handshake FSM that has a timeout, empty detection, a pop counter and an optional auto-pop on the last data word. It sits between the host bus decoder and the TSU queues, all in one clock domain.

## Interface
- NUM_CH, 2, channel count, 1..8
- Q_WORDS, 4, 32-bit words per queue entry, 1..4
- RD_TIMEOUT, 15, cycles to wait for q_rd_vld_in before abort, 1..255
- clk  in  1  bus and queue clock
- rst  in  1  asynchronous, active-low reset
- wr_in  in  1  write strobe
- rd_in  in  1  read strobe
- addr_in  in  8  byte address; channel = addr_in[7:5], offset = addr_in[4:2]
- data_in  in  32  write data
- data_out  out  32  registered read data
- q_rst_out  out  NUM_CH  one-cycle queue reset pulse per channel
- q_rd_en_out  out  NUM_CH  one-cycle queue pop pulse per channel
- q_rd_vld_in  in  NUM_CH  queue data valid, one cycle, any time after pop
- q_data_in  in  NUM_CH*Q_WORDS*32  queue head data; word 0 in the MSBs of each channel slice
- q_stat_in  in  NUM_CH*8  queue fill level
- q_ptp_msgid_mask_out  out  NUM_CH*8  per-channel message-ID mask
- irq_out  out  1  interrupt, level

## Operation
- Per-channel map (base ch*0x20): 0x00 CTRL, 0x04 STAT, 0x08 MASK [31:24], 0x0C reads 0, 0x10+4k DATA word k for k < Q_WORDS; other offsets and channels >= NUM_CH read 0, writes ignored.
- CTRL write: bit0 RD_REQ and bit1 Q_RST are self-clearing commands and read 0. bit2 AUTO_POP and bit3 IRQ_EN are stored.
- STAT: [7:0] q_stat_in (sampled), [8] BUSY, [9] OK, [10] TIMEOUT (sticky), [11] EMPTY, [31:16] POP_CNT. A write of 1 to [10] clears TIMEOUT. A write of 1 to [11] clears EMPTY.
- FSM states per channel:
  - IDLE -> REQ on RD_REQ. If the sampled q_stat_in is 0, the channel stays in IDLE, EMPTY is set and no pop is issued.
  - REQ: q_rd_en_out pulses for 1 cycle, OK is cleared, timer is loaded, then -> WAIT.
  - WAIT -> IDLE on q_rd_vld_in: capture the slice into shadow DATA, set OK, POP_CNT+1 (16-bit wrap 0xFFFF->0).
  - WAIT -> IDLE when the timer expires after RD_TIMEOUT cycles: set TIMEOUT, OK stays 0, shadow is unchanged.
- RD_REQ while BUSY (REQ/WAIT) is ignored.
- Q_RST at any state: q_rst_out pulses once, FSM -> IDLE, OK/EMPTY/POP_CNT cleared, shadow kept, a q_rd_vld_in in the same cycle is discarded.
- Auto-pop: with AUTO_POP=1, a bus read of the last DATA word (offset 0x10+4*(Q_WORDS-1)) in IDLE acts as RD_REQ.
- Read and write to the same register in one cycle: data_out returns the pre-write value.
- Reset: all outputs 0, all registers 0, FSMs IDLE.

## Timing
- data_out updates on the clk edge after rd_in and holds its value otherwise.
- RD_REQ written at edge T: REQ during T..T+1, q_rd_en_out high for T+1..T+2. The earliest q_rd_vld_in is sampled at T+2, which sets OK and captures DATA at T+2. A STAT read presented after T+2 returns OK=1.
- Timeout: if no valid has arrived, TIMEOUT sets exactly RD_TIMEOUT cycles after entering WAIT.
- q_rst_out asserts the cycle after the CTRL write.
- BUSY is 1 throughout REQ and WAIT.

## Configuration
- TSU_Q_IRQ_EN defined: irq_out = OR over channels of IRQ_EN & (OK | TIMEOUT | q_stat_in != 0), registered, 1-cycle latency.
- TSU_Q_IRQ_EN undefined: irq_out is tied 0, CTRL bit3 is not stored and reads 0.

## Test plan
- Reset mid-WAIT (rst low for 1 cycle) -> all outputs 0, BUSY=0, POP_CNT=0 immediately.
- ch1, q_stat=3, write CTRL=0x1, vld 4 cycles later with data 0xA..D -> one q_rd_en_out pulse; STAT=0x0001_0203; DATA reads 0xA, 0xB, 0xC, 0xD.
- RD_REQ with q_stat=0 -> no pop, STAT[11]=1; W1C of bit 11 -> 0.
- RD_TIMEOUT=15, no vld -> TIMEOUT set 15 cycles after WAIT entry, OK=0, BUSY=0; a vld arriving later has no effect.
- AUTO_POP=1, read ch0 0x1C three times with valid responses -> three pops, POP_CNT=3. A second RD_REQ while BUSY produces no extra pulse.
- Q_RST during WAIT, simultaneous with vld -> data discarded, OK=0, POP_CNT=0, one q_rst_out pulse. With TSU_Q_IRQ_EN and IRQ_EN=1, irq_out rises 1 cycle after OK sets.
